// File: rtl/arc4_pkg.sv
// Shared definitions for the ARC4 pipeline stages (init, ksa, prga).
// State encodings and memory/key sizes live here so every stage agrees on them.
package arc4_pkg;

  localparam int S_SIZE    = 256;
  localparam int KEY_BYTES = 3;

  typedef enum logic [2:0] {
    IDLE,
    RD_I,
    LAT_I,
    RD_J,
    LAT_J,
    WR_I,
    WR_J
  } ksa_state_t;

endpackage

// File: rtl/ksa.sv
// ARC4 key-scheduling stage: permutes the shared S memory in place using the key,
// six cycles per index, with registered (Moore) memory-port outputs and an en/rdy handshake.
module ksa #(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   rdy,
  input  logic [KEY_BYTES*8-1:0] key,
  output logic [7:0]             addr,
  input  logic [7:0]             rddata,
  output logic [7:0]             wrdata,
  output logic                   wren
);
  import arc4_pkg::*;

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  ksa_state_t             state, next_state;
  logic [7:0]             i, j, si, sj;
  logic [7:0]             next_i, next_j, next_si, next_sj;
  logic [KW-1:0]          kidx, next_kidx;
  logic [KEY_BYTES*8-1:0] key_q, next_key;
  logic [7:0]             next_addr, next_wrdata;
  logic                   next_wren, next_rdy;
  logic [7:0]             key_byte;
  logic [7:0]             j_sum;

  // Byte 0 of the key sits in the most significant byte position.
  always_comb begin
    key_byte = key_q[8*(KEY_BYTES-1-int'(kidx)) +: 8];
    j_sum    = j + rddata + key_byte;
  end

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    next_state  = state;
    next_i      = i;
    next_j      = j;
    next_si     = si;
    next_sj     = sj;
    next_kidx   = kidx;
    next_key    = key_q;
    next_addr   = 8'd0;
    next_wrdata = 8'd0;
    next_wren   = 1'b0;
    next_rdy    = 1'b0;

    case (state)
      IDLE: begin
        next_rdy = 1'b1;
        if (en) begin
          next_state = RD_I;
          next_key   = key;
          next_i     = 8'd0;
          next_j     = 8'd0;
          next_kidx  = '0;
          next_rdy   = 1'b0;
        end
      end
      RD_I: begin
        next_state = LAT_I;
      end
      LAT_I: begin
        next_si    = rddata;
        next_j     = j_sum;
        next_addr  = j_sum;
        next_state = RD_J;
      end
      RD_J: begin
        next_state = LAT_J;
      end
      LAT_J: begin
        next_sj     = rddata;
        next_addr   = i;
        next_wrdata = rddata;
        next_wren   = 1'b1;
        next_state  = WR_I;
      end
      WR_I: begin
        next_addr   = j;
        next_wrdata = si;
        next_wren   = 1'b1;
        next_state  = WR_J;
      end
      WR_J: begin
        if (i == 8'(S_SIZE - 1)) begin
          next_state = IDLE;
          next_rdy   = 1'b1;
        end else begin
          next_i     = i + 8'd1;
          next_addr  = i + 8'd1;
          next_kidx  = (kidx == KW'(KEY_BYTES - 1)) ? '0 : kidx + 1'b1;
          next_state = RD_I;
        end
      end
      default: begin
        next_state = IDLE;
        next_rdy   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      i      <= 8'd0;
      j      <= 8'd0;
      si     <= 8'd0;
      sj     <= 8'd0;
      kidx   <= '0;
      key_q  <= '0;
      addr   <= 8'd0;
      wrdata <= 8'd0;
      wren   <= 1'b0;
      rdy    <= 1'b1;
    end else begin
      state  <= next_state;
      i      <= next_i;
      j      <= next_j;
      si     <= next_si;
      sj     <= next_sj;
      kidx   <= next_kidx;
      key_q  <= next_key;
      addr   <= next_addr;
      wrdata <= next_wrdata;
      wren   <= next_wren;
      rdy    <= next_rdy;
    end
  end

endmodule
